// File: rtl/logic_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : logic_mux_pkg
//  Description : Shared types and helpers for the N-channel registered mux
//                and its round-robin arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package logic_mux_pkg;

    // Channel-selection mode as presented on mode_i
    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_RR     = 1'b1
    } mux_mode_e;

    // Modulo-n increment; any idx >= n-1 wraps to 0 so results stay below n
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return ((idx + 1) >= n) ? 0 : (idx + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/logic_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : logic_rr_arb
//  Description : Combinational rotate-priority arbiter. Searches requests
//                starting at ptr+1 and wrapping modulo N_CH.
//  Revision    : 1.0 - initial release
// ============================================================================
module logic_rr_arb
    import logic_mux_pkg::*;
#(
    parameter  int N_CH  = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [SEL_W-1:0] gnt_idx
);

    int unsigned      w_cand;
    logic [SEL_W-1:0] w_cand_idx;

    // Walk every channel once, starting after the last winner; first hit wins
    always_comb begin
        gnt_valid  = 1'b0;
        gnt_idx    = '0;
        w_cand     = 32'(ptr);
        w_cand_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_cand     = next_idx(w_cand, N_CH);
            w_cand_idx = SEL_W'(w_cand);
            if (!gnt_valid && req[w_cand_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = w_cand_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/logic_muxn_arb.sv
`default_nettype none
// ============================================================================
//  Module      : logic_muxn_arb
//  Description : N-channel, WIDTH-bit registered multiplexer with direct or
//                round-robin channel selection and a one-entry valid/ready
//                output register.
//  Revision    : 1.0 - initial release
// ============================================================================
module logic_muxn_arb
    import logic_mux_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N_CH  = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode_i,
    input  logic [SEL_W-1:0]      sel_i,
    input  logic [N_CH*WIDTH-1:0] in_data_i,
    input  logic [N_CH-1:0]       in_valid_i,
    output logic [N_CH-1:0]       in_ready_o,
    output logic [WIDTH-1:0]      out_data_o,
    output logic [SEL_W-1:0]      out_ch_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i
);

    localparam logic [SEL_W-1:0] c_ptr_rst = SEL_W'(N_CH - 1);

    // Output register; r_out_valid is the EMPTY/FULL state
    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_ch;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_rr_ptr;

    mux_mode_e        w_mode;
    logic             w_load_en;
    logic             w_sel_in_range;
    logic             w_dir_valid;
    logic             w_rr_valid;
    logic [SEL_W-1:0] w_rr_idx;
    logic             w_gnt_valid;
    logic [SEL_W-1:0] w_gnt_idx;
    logic [WIDTH-1:0] w_gnt_data;
    logic [N_CH-1:0]  w_ready;

    assign w_mode    = mux_mode_e'(mode_i);
    assign w_load_en = !r_out_valid || out_ready_i;

    logic_rr_arb #(
        .N_CH (N_CH)
    ) u_rr_arb (
        .req       (in_valid_i),
        .ptr       (r_rr_ptr),
        .gnt_valid (w_rr_valid),
        .gnt_idx   (w_rr_idx)
    );

    // Pick the grant source; out-of-range selects simply produce no grant
    always_comb begin
        w_sel_in_range = ({{(32-SEL_W){1'b0}}, sel_i} < 32'(N_CH));
        w_dir_valid    = w_sel_in_range && in_valid_i[sel_i];
        if (w_mode == MODE_DIRECT) begin
            w_gnt_valid = w_load_en && w_dir_valid;
            w_gnt_idx   = sel_i;
        end else begin
            w_gnt_valid = w_load_en && w_rr_valid;
            w_gnt_idx   = w_rr_idx;
        end
    end

    // Winner's data and the one-hot ready fan-out; reset suppresses all accepts
    always_comb begin
        w_gnt_data = '0;
        w_ready    = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (w_gnt_idx == SEL_W'(k)) begin
                w_gnt_data = in_data_i[k*WIDTH +: WIDTH];
                w_ready[k] = !rst && w_gnt_valid;
            end
        end
    end

    // Output register load/drain and round-robin pointer update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_rr_ptr    <= c_ptr_rst;
        end else if (w_load_en) begin
            if (w_gnt_valid) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_gnt_data;
                r_out_ch    <= w_gnt_idx;
                r_rr_ptr    <= w_gnt_idx;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready_o  = w_ready;
    assign out_data_o  = r_out_data;
    assign out_ch_o    = r_out_ch;
    assign out_valid_o = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_logic_muxn_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_logic_muxn_arb
//  Description : Self-checking bench for logic_muxn_arb (WIDTH=8, N_CH=4).
//                Reference model predicts grants; a queue carries expected
//                output words from acceptance to emission.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_muxn_arb;

    localparam int WIDTH = 8;
    localparam int N_CH  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode_i;
    logic [1:0]  sel_i;
    logic [31:0] in_data_i;
    logic [3:0]  in_valid_i;
    logic [3:0]  in_ready_o;
    logic [7:0]  out_data_o;
    logic [1:0]  out_ch_o;
    logic        out_valid_o;
    logic        out_ready_i;

    int          n_vec = 0;
    int          n_err = 0;
    logic [9:0]  sb_q[$];      // {ch, data}
    logic        m_valid = 1'b0;
    logic [1:0]  m_ptr   = 2'd3;
    logic [7:0]  rr_exp [5];

    always #5 clk = ~clk;

    logic_muxn_arb #(
        .WIDTH (WIDTH),
        .N_CH  (N_CH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode_i      (mode_i),
        .sel_i       (sel_i),
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .out_data_o  (out_data_o),
        .out_ch_o    (out_ch_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: check DUT against the model at negedge, advance model, step past posedge
    task automatic tick();
        logic       load;
        logic       g;
        logic [1:0] idx;
        logic [1:0] c;
        logic [3:0] er;
        @(negedge clk);
        load = !m_valid || out_ready_i;
        g    = 1'b0;
        idx  = 2'd0;
        if (!rst && load) begin
            if (mode_i == 1'b0) begin
                idx = sel_i;
                g   = in_valid_i[sel_i];
            end else begin
                for (int k = 1; k <= N_CH; k++) begin
                    c = m_ptr + 2'(k);
                    if (!g && in_valid_i[c]) begin
                        g   = 1'b1;
                        idx = c;
                    end
                end
            end
        end
        er = g ? (4'b0001 << idx) : 4'b0000;
        chk("in_ready", 32'(in_ready_o), 32'(er));
        chk("out_valid", 32'(out_valid_o), 32'(m_valid));
        if (m_valid) begin
            chk("sb_depth", sb_q.size(), 1);
            if (sb_q.size() > 0) begin
                chk("out_data", 32'(out_data_o), 32'(sb_q[0][7:0]));
                chk("out_ch", 32'(out_ch_o), 32'(sb_q[0][9:8]));
                if (out_ready_i) void'(sb_q.pop_front());
            end
        end
        if (rst) begin
            m_valid = 1'b0;
            m_ptr   = 2'd3;
            sb_q.delete();
        end else if (load) begin
            if (g) begin
                sb_q.push_back({idx, in_data_i[idx*8 +: 8]});
                m_valid = 1'b1;
                m_ptr   = idx;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        mode_i      = 1'b1;
        sel_i       = 2'd0;
        in_data_i   = 32'h13121110;
        in_valid_i  = 4'b1111;
        out_ready_i = 1'b1;
        @(posedge clk);
        #1;

        // Reset held for 2 cycles with every channel requesting
        tick();
        tick();
        chk("rst_data", 32'(out_data_o), 32'h0);
        chk("rst_ch", 32'(out_ch_o), 32'h0);
        chk("rst_valid", 32'(out_valid_o), 32'h0);
        rst = 1'b0;

        // Direct select of ch2, then a select pointing at an idle channel
        mode_i     = 1'b0;
        sel_i      = 2'd2;
        in_data_i  = 32'h00A50000;
        in_valid_i = 4'b0100;
        tick();
        chk("dir_data", 32'(out_data_o), 32'hA5);
        chk("dir_ch", 32'(out_ch_o), 32'h2);
        sel_i = 2'd1;
        tick();
        chk("dir_nogrant", 32'(out_valid_o), 32'h0);

        // Round-robin wrap from a fresh reset
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        mode_i     = 1'b1;
        in_data_i  = 32'h13121110;
        in_valid_i = 4'b1111;
        rr_exp     = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_seq", 32'(out_data_o), 32'(rr_exp[i]));
        end

        // Back-pressure: hold 0x11 for three stalled cycles, then resume
        tick();
        chk("bp_load", 32'(out_data_o), 32'h11);
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold", 32'(out_data_o), 32'h11);
        end
        out_ready_i = 1'b1;
        tick();
        chk("bp_resume", 32'(out_data_o), 32'h12);

        // Mode switch keeps round-robin fairness
        in_valid_i = 4'b0010;
        tick();
        chk("ms_rr_ch1", 32'(out_ch_o), 32'h1);
        mode_i     = 1'b0;
        sel_i      = 2'd3;
        in_valid_i = 4'b1000;
        tick();
        chk("ms_dir_ch3", 32'(out_ch_o), 32'h3);
        mode_i     = 1'b1;
        in_valid_i = 4'b1111;
        tick();
        chk("ms_rr_ch0", 32'(out_ch_o), 32'h0);

        // Reset while stalled
        out_ready_i = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("rst_stall_valid", 32'(out_valid_o), 32'h0);
        rst         = 1'b0;
        out_ready_i = 1'b1;
        tick();
        chk("rst_first_ch", 32'(out_ch_o), 32'h0);

        // Randomised traffic against the model
        for (int i = 0; i < 40; i++) begin
            mode_i      = 1'($urandom_range(1));
            sel_i       = 2'($urandom_range(3));
            in_valid_i  = 4'($urandom_range(15));
            in_data_i   = $urandom;
            out_ready_i = ($urandom_range(3) != 0);
            tick();
        end

        // Drain
        in_valid_i  = 4'b0000;
        out_ready_i = 1'b1;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
